// File: rtl/rv32_exec_datapath.sv
// rv32_exec_datapath: single-cycle RV32I execute stage.
// Holds the 32x32 register file, the integer ALU, the store address/data
// path and a byte-lane data memory. Reads are combinational; register and
// memory writes commit on the rising edge of clock.
module rv32_exec_datapath #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [31:0] imm,
    input  logic [3:0]  mem_write_enable,
    input  logic        store_enable,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] alu_result,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_read_data
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Entry 0 is never written; the read mux forces x0 to zero instead.
    logic [31:0] r_regs [0:31];
    logic [31:0] r_mem  [0:MEM_WORDS-1];

    logic          w_is_r;
    logic          w_alt;
    logic [31:0]   w_b;
    logic [4:0]    w_shamt;
    logic [31:0]   w_alu;
    logic [31:0]   w_store_data;
    logic [AW-1:0] w_word_idx;

    // Register file read ports; no bypass, so a same-cycle write is not seen.
    assign rs1_data = (rs1 == 5'd0) ? 32'd0 : r_regs[rs1];
    assign rs2_data = (rs2 == 5'd0) ? 32'd0 : r_regs[rs2];

    assign w_is_r  = (opcode == OP_R);
    assign w_alt   = (func7 == 7'b0100000);
    assign w_b     = w_is_r ? rs2_data : imm;
    assign w_shamt = w_b[4:0];

    // Store address; upper address bits beyond the array are dropped so the
    // word index wraps around the memory.
    assign mem_addr      = rs1_data + imm;
    assign w_word_idx    = mem_addr[AW+1:2];
    assign mem_read_data = r_mem[w_word_idx];

    // Integer ALU shared by R-type and I-type; SUB exists only for R-type.
    always_comb begin
        w_alu = 32'd0;
        case (func3)
            3'b000: w_alu = (w_is_r && w_alt) ? (rs1_data - w_b) : (rs1_data + w_b);
            3'b001: w_alu = rs1_data << w_shamt;
            3'b010: w_alu = ($signed(rs1_data) < $signed(w_b)) ? 32'd1 : 32'd0;
            3'b011: w_alu = (rs1_data < w_b) ? 32'd1 : 32'd0;
            3'b100: w_alu = rs1_data ^ w_b;
            3'b101: w_alu = w_alt ? $unsigned($signed(rs1_data) >>> w_shamt)
                                  : (rs1_data >> w_shamt);
            3'b110: w_alu = rs1_data | w_b;
            3'b111: w_alu = rs1_data & w_b;
            default: w_alu = 32'd0;
        endcase
    end

    // Result select by opcode; unknown opcodes produce zero.
    always_comb begin
        alu_result = 32'd0;
        case (opcode)
            OP_R, OP_I: alu_result = w_alu;
            OP_LUI:     alu_result = imm;
            OP_STORE:   alu_result = mem_addr;
            default:    alu_result = 32'd0;
        endcase
    end

    // Replicate the store operand across lanes so any strobe pattern picks
    // the correct byte/halfword without a shifter.
    always_comb begin
        w_store_data = rs2_data;
        case (func3)
            3'b000:  w_store_data = {4{rs2_data[7:0]}};
            3'b001:  w_store_data = {2{rs2_data[15:0]}};
            default: w_store_data = rs2_data;
        endcase
    end

    // Register file write-back; reset clears every entry and blocks the write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (reg_write && (rd != 5'd0)) begin
            r_regs[rd] <= alu_result;
        end
    end

    // Byte-lane memory write; contents survive reset but reset drops the write.
    always_ff @(posedge clock) begin
        if (!reset && store_enable) begin
            for (int n = 0; n < 4; n++) begin
                if (mem_write_enable[n]) begin
                    r_mem[w_word_idx][8*n +: 8] <= w_store_data[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32_exec_datapath.sv
// tb_rv32_exec_datapath: directed vectors with hand-computed expectations.
module tb_rv32_exec_datapath;

    localparam int MEM_WORDS = 256;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    logic        clock = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic [3:0]  mem_write_enable;
    logic        store_enable;
    logic [31:0] rs1_data, rs2_data, alu_result, mem_addr, mem_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    rv32_exec_datapath #(.MEM_WORDS(MEM_WORDS)) dut (
        .clock            (clock),
        .reset            (reset),
        .reg_write        (reg_write),
        .rd               (rd),
        .rs1              (rs1),
        .rs2              (rs2),
        .opcode           (opcode),
        .func3            (func3),
        .func7            (func7),
        .imm              (imm),
        .mem_write_enable (mem_write_enable),
        .store_enable     (store_enable),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .alu_result       (alu_result),
        .mem_addr         (mem_addr),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one instruction's decoded fields, then settle.
    task automatic drive(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im, input logic rw,
                         input logic se, input logic [3:0] strb);
        opcode = op; func3 = f3; func7 = f7; rd = d; rs1 = s1; rs2 = s2;
        imm = im; reg_write = rw; store_enable = se; mem_write_enable = strb;
        #1;
        $display("[%0t] %-8s op=%b f3=%b rd=%0d rs1=%0d rs2=%0d imm=%h -> alu=%h addr=%h",
                 $time, name, op, f3, d, s1, s2, im, alu_result, mem_addr);
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reg_write = 1'b0; store_enable = 1'b0; mem_write_enable = 4'b0000;
    endtask

    task automatic read_reg(input logic [4:0] idx, input logic [31:0] exp, input string tag);
        idle();
        rs1 = idx; rs2 = idx;
        #1;
        check_eq(tag, rs1_data, exp);
    endtask

    task automatic alu_check(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                             input logic [31:0] im, input logic [31:0] exp);
        drive(name, op, f3, f7, 5'd0, s1, s2, im, 1'b0, 1'b0, 4'b0000);
        check_eq(name, alu_result, exp);
    endtask

    initial begin
        reset = 1'b1;
        opcode = 7'd0; func3 = 3'd0; func7 = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        imm = 32'd0; reg_write = 1'b0; store_enable = 1'b0; mem_write_enable = 4'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state of every register on both ports.
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(i);
            #1;
            check_eq($sformatf("rst_rs1_x%0d", i), rs1_data, 32'd0);
            check_eq($sformatf("rst_rs2_x%0d", i), rs2_data, 32'd0);
        end

        // ADDI x1, x0, 5 ; rs2 observes x1 to confirm no same-cycle bypass.
        drive("addi_x1", OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd1, 32'd5, 1'b1, 1'b0, 4'd0);
        check_eq("addi_x1_alu", alu_result, 32'd5);
        check_eq("no_bypass", rs2_data, 32'd0);
        tick();
        read_reg(5'd1, 32'd5, "x1_eq_5");

        // ADDI x0, x0, 5 must leave x0 at zero.
        drive("addi_x0", OP_I, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0, 4'd0);
        tick();
        read_reg(5'd0, 32'd0, "x0_stays_0");

        // ADDI x2, x0, -3
        drive("addi_x2", OP_I, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFD, 1'b1, 1'b0, 4'd0);
        tick();
        read_reg(5'd2, 32'hFFFF_FFFD, "x2_eq_m3");

        // R-type with x1=5, x2=-3.
        alu_check("add",   OP_R, 3'b000, 7'd0,   5'd1, 5'd2, 32'd0, 32'd2);
        alu_check("sub",   OP_R, 3'b000, F7_ALT, 5'd1, 5'd2, 32'd0, 32'd8);
        alu_check("slt",   OP_R, 3'b010, 7'd0,   5'd2, 5'd1, 32'd0, 32'd1);
        alu_check("sltu",  OP_R, 3'b011, 7'd0,   5'd2, 5'd1, 32'd0, 32'd0);
        alu_check("sll",   OP_R, 3'b001, 7'd0,   5'd1, 5'd1, 32'd0, 32'h0000_00A0);
        alu_check("sra5",  OP_R, 3'b101, F7_ALT, 5'd2, 5'd1, 32'd0, 32'hFFFF_FFFF);
        alu_check("srl5",  OP_R, 3'b101, 7'd0,   5'd2, 5'd1, 32'd0, 32'h07FF_FFFF);
        alu_check("xor",   OP_R, 3'b100, 7'd0,   5'd1, 5'd2, 32'd0, 32'hFFFF_FFF8);
        alu_check("or",    OP_R, 3'b110, 7'd0,   5'd1, 5'd2, 32'd0, 32'hFFFF_FFFD);
        alu_check("and",   OP_R, 3'b111, 7'd0,   5'd1, 5'd2, 32'd0, 32'd5);
        // Shift by 1 via immediate form.
        alu_check("srai1", OP_I, 3'b101, F7_ALT, 5'd2, 5'd0, 32'd1, 32'hFFFF_FFFE);
        alu_check("srli1", OP_I, 3'b101, 7'd0,   5'd2, 5'd0, 32'd1, 32'h7FFF_FFFE);
        // I-type with func7=0100000 on func3=000 is still ADD.
        alu_check("addi_f7", OP_I, 3'b000, F7_ALT, 5'd1, 5'd0, 32'd3, 32'd8);

        // x1=8, x3=0xA1B2C3D4 (LUI + ADDI), x4=0x77.
        drive("addi_x1", OP_I, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 1'b0, 4'd0);
        tick();
        drive("lui_x3", OP_LUI, 3'b000, 7'd0, 5'd3, 5'd0, 5'd0, 32'hA1B2_C000, 1'b1, 1'b0, 4'd0);
        tick();
        drive("addi_x3", OP_I, 3'b000, 7'd0, 5'd3, 5'd3, 5'd0, 32'h0000_03D4, 1'b1, 1'b0, 4'd0);
        tick();
        drive("addi_x4", OP_I, 3'b000, 7'd0, 5'd4, 5'd0, 5'd0, 32'h0000_0077, 1'b1, 1'b0, 4'd0);
        tick();
        read_reg(5'd3, 32'hA1B2_C3D4, "x3_value");

        // SW x3, 4(x1)
        drive("sw", OP_STORE, 3'b010, 7'd0, 5'd0, 5'd1, 5'd3, 32'd4, 1'b0, 1'b1, 4'b1111);
        check_eq("sw_addr", mem_addr, 32'd12);
        check_eq("sw_alu", alu_result, 32'd12);
        tick();
        idle();
        #1;
        check_eq("sw_read", mem_read_data, 32'hA1B2_C3D4);

        // SB x4, 4(x1) into lane 1.
        drive("sb", OP_STORE, 3'b000, 7'd0, 5'd0, 5'd1, 5'd4, 32'd4, 1'b0, 1'b1, 4'b0010);
        tick();
        idle();
        #1;
        check_eq("sb_read", mem_read_data, 32'hA1B2_77D4);

        // Word index wraps: address 12 + 4*MEM_WORDS aliases word 3.
        drive("wrap", OP_I, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'(12 + 4*MEM_WORDS), 1'b0, 1'b0, 4'd0);
        check_eq("wrap_read", mem_read_data, 32'hA1B2_77D4);

        // Reset together with a register write and a memory write.
        reset = 1'b1;
        drive("rst_wr", OP_I, 3'b010, 7'd0, 5'd5, 5'd0, 5'd4, 32'd12, 1'b1, 1'b1, 4'b1111);
        tick();
        reset = 1'b0;
        read_reg(5'd5, 32'd0, "rst_blocks_x5");
        read_reg(5'd1, 32'd0, "rst_clears_x1");
        drive("mem_chk", OP_I, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd12, 1'b0, 1'b0, 4'd0);
        check_eq("rst_mem_keep", mem_read_data, 32'hA1B2_77D4);

        // Operation resumes right after reset.
        drive("addi_x5", OP_I, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'd7, 1'b1, 1'b0, 4'd0);
        tick();
        read_reg(5'd5, 32'd7, "resume_x5");

        // LUI x6 and an undefined opcode.
        drive("lui_x6", OP_LUI, 3'b000, 7'd0, 5'd6, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 1'b0, 4'd0);
        check_eq("lui_alu", alu_result, 32'h1234_5000);
        tick();
        read_reg(5'd6, 32'h1234_5000, "x6_lui");
        alu_check("bad_op", OP_BAD, 3'b000, 7'd0, 5'd6, 5'd5, 32'd1, 32'd0);

        // Register write and store in the same edge; SH x5 (=7) into upper half.
        drive("sh+wr", OP_STORE, 3'b001, 7'd0, 5'd7, 5'd0, 5'd5, 32'd12, 1'b1, 1'b1, 4'b1100);
        tick();
        read_reg(5'd7, 32'd12, "dual_x7");
        drive("mem_chk", OP_I, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd12, 1'b0, 1'b0, 4'd0);
        check_eq("sh_read", mem_read_data, 32'h0007_77D4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
